restoring_divider_8_bits: RTL

- Sequential unsigned 8-bit restoring divider. Computes quotient and remainder of dividend / divisor, one quotient bit per clock.
- Sits directly downstream of the 8-bit ripple-borrow subtractor. It owns the partial-remainder and quotient registers, feeds each trial subtraction into the subtractor, and consumes its difference and borrow-out.
- Used as the iterative arithmetic stage above the combinational subtractor datapath.

---
 rtl/restoring_divider_8_bits_pkg.sv | 14 +
 rtl/restoring_divider_8_bits_if.sv | 23 ++
 rtl/r_c_8_bit_subtractor.sv | 21 ++
 rtl/restoring_divider_8_bits.sv | 135 +++++++++++++
 4 files changed

// File: rtl/restoring_divider_8_bits_pkg.sv
// Shared types and constants for the 8-bit restoring divider slice.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         WIDTH_C       = 8;
    localparam logic [2:0] ITER_LAST     = 3'd7;
    localparam logic [7:0] QUOT_ZERO_DIV = 8'hFF;

endpackage

// File: rtl/restoring_divider_8_bits_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface restoring_divider_8_bits_if;

    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/r_c_8_bit_subtractor.sv
// 8-bit ripple-borrow subtractor: d = x - y - z, b is the borrow out of bit 7.
module r_c_8_bit_subtractor (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       z,
    output logic [7:0] d,
    output logic       b
);

    logic [8:0] bw;

    assign bw[0] = z;

    for (genvar i = 0; i < 8; i++) begin : g_stage
        assign d[i]    = x[i] ^ y[i] ^ bw[i];
        assign bw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw[i]);
    end

    assign b = bw[8];

endmodule

// File: rtl/restoring_divider_8_bits.sv
// Sequential unsigned 8-bit restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and flags div_by_zero.
module restoring_divider_8_bits
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
) (
    input logic                       clk,
    input logic                       rst,
    restoring_divider_8_bits_if.slave bus
);

    if (WIDTH != WIDTH_C) begin : g_width_check
        $error("restoring_divider_8_bits supports only WIDTH=8");
    end

    state_t     state_q, state_d;
    logic [7:0] dreg, qreg, rreg;
    logic [2:0] count;
    logic [7:0] quotient_q, remainder_q;
    logic       accept, last_step;
    logic [8:0] rs;
    logic [7:0] diff, r_next, q_next;
    logic       borrow, ok;
`ifdef DIV_ZERO_FAST_EN
    logic       zero_pend;
    logic       dbz_q;
`endif

    // Trial subtraction; a set rs[8] means the partial remainder already exceeds the divisor.
    assign rs = {rreg, qreg[7]};

    r_c_8_bit_subtractor u_sub (
        .x (rs[7:0]),
        .y (dreg),
        .z (1'b0),
        .d (diff),
        .b (borrow)
    );

    assign ok     = ~borrow | rs[8];
    assign r_next = ok ? diff : rs[7:0];
    assign q_next = {qreg[6:0], ok};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
`ifdef DIV_ZERO_FAST_EN
                if (zero_pend) begin
                    state_d = DONE;
                end else
`endif
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.divisor == 8'd0) state_d = IDLE;
`endif
                end
            end
            RUN: begin
                if (count == ITER_LAST) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dreg        <= '0;
            qreg        <= '0;
            rreg        <= '0;
            count       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_FAST_EN
            zero_pend   <= 1'b0;
            dbz_q       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                dreg  <= bus.divisor;
                qreg  <= bus.dividend;
                rreg  <= '0;
                count <= '0;
`ifdef DIV_ZERO_FAST_EN
                zero_pend <= (bus.divisor == 8'd0);
`endif
            end else if (state_q == RUN) begin
                rreg  <= r_next;
                qreg  <= q_next;
                count <= count + 3'd1;
            end
            if (last_step) begin
                quotient_q  <= q_next;
                remainder_q <= r_next;
`ifdef DIV_ZERO_FAST_EN
                dbz_q       <= 1'b0;
`endif
            end
`ifdef DIV_ZERO_FAST_EN
            // The pending cycle retires a zero-divisor request; qreg still holds the dividend.
            if (zero_pend && state_q == IDLE) begin
                quotient_q  <= QUOT_ZERO_DIV;
                remainder_q <= qreg;
                dbz_q       <= 1'b1;
                zero_pend   <= 1'b0;
            end
`endif
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
`ifdef DIV_ZERO_FAST_EN
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule
